modulation_ctrl: RTL and testbench

MODULATION_CTRL -- requirements
Module: modulation_ctrl

---
 rtl/mod_pkg.sv | 29 ++
 rtl/edge_sync.sv | 35 +++
 rtl/modulation_ctrl.sv | 159 +++++++++++++++
 tb/tb_modulation_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// Shared types and helpers for the modulation controller.
package mod_pkg;

    typedef enum logic [1:0] {
        ASK  = 2'd0,
        FSK  = 2'd1,
        BPSK = 2'd2,
        QPSK = 2'd3
    } mod_mode_e;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ACTIVE    = 2'd1,
        STUCK     = 2'd2
    } ctrl_state_e;

    // Two's-complement negate of a w-bit value carried in 32 bits; the most
    // negative code maps to the most positive one instead of wrapping.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                   input int unsigned       w);
        logic signed [31:0] min_v;
        min_v = -(32'sd1 <<< (w - 32'd1));
        if (x == min_v) begin
            return (32'sd1 <<< (w - 32'd1)) - 32'sd1;
        end
        return -x;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for a slow level plus a registered rising-edge tick.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_tick
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic       r_tick;
    logic [1:0] r_fill;

    // r_fill marks when r_sync2 holds a real sample; until then r_prev is
    // held high so a level already high at reset release never ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_fill  <= 2'b00;
            r_prev  <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            r_sync1 <= i_level;
            r_sync2 <= r_sync1;
            r_fill  <= {r_fill[0], 1'b1};
            r_prev  <= r_fill[1] ? r_sync2 : 1'b1;
            r_tick  <= r_fill[1] & r_sync2 & ~r_prev;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/modulation_ctrl.sv
// Symbol-rate modulation controller: latches a symbol and mode on each
// synchronized clk_1hz edge and forms ASK/FSK/BPSK/QPSK samples from the DDS.
module modulation_ctrl
    import mod_pkg::*;
#(
    parameter int unsigned              DATA_W    = 12,
    parameter int unsigned              PHASE_W   = 32,
    parameter logic [PHASE_W-1:0]       FSK_INC_0 = PHASE_W'(85899),
    parameter logic [PHASE_W-1:0]       FSK_INC_1 = PHASE_W'(171799)
) (
    input  logic                      CLK_50,
    input  logic                      reset_n,
    input  logic                      clk_1hz,
    input  logic [4:0]                lfsr,
    input  logic [1:0]                mod_sel,
    input  logic signed [DATA_W-1:0]  sin_in,
    input  logic signed [DATA_W-1:0]  cos_in,
    output logic [PHASE_W-1:0]        phase_inc,
    output logic signed [DATA_W-1:0]  mod_out,
    output logic                      sym_valid,
    output logic                      lfsr_stuck
);

    localparam int unsigned SUM_W = DATA_W + 1;

    logic                      w_tick;
    logic                      w_lfsr_zero;
    logic                      w_latch;

    ctrl_state_e               r_state;
    ctrl_state_e               w_state_nxt;
    logic [1:0]                r_sym_bits;
    logic [1:0]                w_bits_nxt;
    mod_mode_e                 r_active_mode;
    mod_mode_e                 w_mode_nxt;
    logic                      r_prev_zero;
    logic                      w_prev_zero_nxt;

    logic signed [DATA_W-1:0]  w_sin_neg;
    logic signed [DATA_W-1:0]  w_cos_neg;
    logic signed [DATA_W-1:0]  w_qpsk_i;
    logic signed [DATA_W-1:0]  w_qpsk_q;
    logic signed [SUM_W-1:0]   w_qsum;

    logic signed [DATA_W-1:0]  r_mod_out;
    logic signed [DATA_W-1:0]  w_mod_nxt;
    logic [PHASE_W-1:0]        r_phase_inc;
    logic [PHASE_W-1:0]        w_inc_nxt;
    logic                      r_sym_valid;
    logic                      r_lfsr_stuck;

    edge_sync u_edge_sync (
        .clk     (CLK_50),
        .rst_n   (reset_n),
        .i_level (clk_1hz),
        .o_tick  (w_tick)
    );

    assign w_lfsr_zero = (lfsr == 5'd0);

    // Next state, symbol latch and zero-history on symbol ticks.
    always_comb begin
        w_state_nxt     = r_state;
        w_bits_nxt      = r_sym_bits;
        w_mode_nxt      = r_active_mode;
        w_prev_zero_nxt = r_prev_zero;
        w_latch         = 1'b0;

        case (r_state)
            WAIT_SYNC: begin
                if (w_tick) begin
                    w_state_nxt = ACTIVE;
                    w_latch     = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_tick) begin
                    if (w_lfsr_zero && r_prev_zero) begin
                        w_state_nxt = STUCK;
                    end else begin
                        w_latch = 1'b1;
                    end
                end
            end
            STUCK: begin
                if (w_tick && !w_lfsr_zero) begin
                    w_state_nxt = ACTIVE;
                    w_latch     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = WAIT_SYNC;
            end
        endcase

        if (w_tick) begin
            w_prev_zero_nxt = w_lfsr_zero;
        end
        if (w_latch) begin
            w_bits_nxt = lfsr[1:0];
            w_mode_nxt = mod_mode_e'(mod_sel);
        end
    end

    // QPSK terms use the saturating negate so the DATA_W+1 sum cannot overflow.
    assign w_sin_neg = DATA_W'(sat_neg(32'(sin_in), DATA_W));
    assign w_cos_neg = DATA_W'(sat_neg(32'(cos_in), DATA_W));
    assign w_qpsk_i  = w_bits_nxt[1] ? cos_in : w_cos_neg;
    assign w_qpsk_q  = w_bits_nxt[0] ? sin_in : w_sin_neg;
    assign w_qsum    = SUM_W'(w_qpsk_i) + SUM_W'(w_qpsk_q);

    // Output values for the coming cycle, driven by the post-tick state and symbol.
    always_comb begin
        w_mod_nxt = '0;
        w_inc_nxt = FSK_INC_0;

        if (w_state_nxt == ACTIVE) begin
            case (w_mode_nxt)
                ASK:  w_mod_nxt = w_bits_nxt[0] ? sin_in : '0;
                FSK: begin
                    w_mod_nxt = sin_in;
                    w_inc_nxt = w_bits_nxt[0] ? FSK_INC_1 : FSK_INC_0;
                end
                BPSK: w_mod_nxt = w_bits_nxt[0] ? sin_in : w_sin_neg;
                QPSK: w_mod_nxt = DATA_W'(w_qsum >>> 1);
                default: w_mod_nxt = '0;
            endcase
        end
    end

    // State, symbol and output registers.
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= WAIT_SYNC;
            r_sym_bits    <= 2'b00;
            r_active_mode <= ASK;
            r_prev_zero   <= 1'b0;
            r_mod_out     <= '0;
            r_phase_inc   <= FSK_INC_0;
            r_sym_valid   <= 1'b0;
            r_lfsr_stuck  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sym_bits    <= w_bits_nxt;
            r_active_mode <= w_mode_nxt;
            r_prev_zero   <= w_prev_zero_nxt;
            r_mod_out     <= w_mod_nxt;
            r_phase_inc   <= w_inc_nxt;
            r_sym_valid   <= w_latch;
            r_lfsr_stuck  <= (w_state_nxt == STUCK);
        end
    end

    assign phase_inc  = r_phase_inc;
    assign mod_out    = r_mod_out;
    assign sym_valid  = r_sym_valid;
    assign lfsr_stuck = r_lfsr_stuck;

endmodule

// File: tb/tb_modulation_ctrl.sv
// Self-checking bench for modulation_ctrl: table of symbols with a
// scoreboard queue, plus hand-written reset and mid-symbol sequences.
`timescale 1ns/1ps
module tb_modulation_ctrl;

    localparam int unsigned        DATA_W  = 12;
    localparam int unsigned        PHASE_W = 32;
    localparam logic [PHASE_W-1:0] INC0    = 32'd85899;
    localparam logic [PHASE_W-1:0] INC1    = 32'd171799;
    localparam logic [1:0]         M_ASK   = 2'd0;
    localparam logic [1:0]         M_FSK   = 2'd1;
    localparam logic [1:0]         M_BPSK  = 2'd2;
    localparam logic [1:0]         M_QPSK  = 2'd3;

    logic                     CLK_50 = 1'b0;
    logic                     reset_n;
    logic                     clk_1hz;
    logic [4:0]               lfsr;
    logic [1:0]               mod_sel;
    logic signed [DATA_W-1:0] sin_in;
    logic signed [DATA_W-1:0] cos_in;
    logic [PHASE_W-1:0]       phase_inc;
    logic signed [DATA_W-1:0] mod_out;
    logic                     sym_valid;
    logic                     lfsr_stuck;

    typedef struct {
        logic signed [DATA_W-1:0] mod;
        logic [PHASE_W-1:0]       inc;
        logic                     valid;
        logic                     stuck;
    } exp_t;

    typedef struct {
        logic [4:0]               lfsr;
        logic [1:0]               sel;
        logic signed [DATA_W-1:0] sin;
        logic signed [DATA_W-1:0] cos;
        exp_t                     e;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    modulation_ctrl #(
        .DATA_W    (DATA_W),
        .PHASE_W   (PHASE_W),
        .FSK_INC_0 (INC0),
        .FSK_INC_1 (INC1)
    ) dut (
        .CLK_50     (CLK_50),
        .reset_n    (reset_n),
        .clk_1hz    (clk_1hz),
        .lfsr       (lfsr),
        .mod_sel    (mod_sel),
        .sin_in     (sin_in),
        .cos_in     (cos_in),
        .phase_inc  (phase_inc),
        .mod_out    (mod_out),
        .sym_valid  (sym_valid),
        .lfsr_stuck (lfsr_stuck)
    );

    always #5 CLK_50 = ~CLK_50;

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK_50);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] l, input logic [1:0] s,
                                input int sn, input int cs, input int m,
                                input logic [PHASE_W-1:0] inc,
                                input logic v, input logic st);
        vec_t r;
        r.lfsr    = l;
        r.sel     = s;
        r.sin     = DATA_W'(sn);
        r.cos     = DATA_W'(cs);
        r.e.mod   = DATA_W'(m);
        r.e.inc   = inc;
        r.e.valid = v;
        r.e.stuck = st;
        return r;
    endfunction

    // Drive one symbol period: raise clk_1hz, expect the result 4 edges later.
    task automatic apply_symbol(input string tag, input vec_t v);
        exp_t e;
        lfsr    = v.lfsr;
        mod_sel = v.sel;
        sin_in  = v.sin;
        cos_in  = v.cos;
        clk_1hz = 1'b1;
        sb_q.push_back(v.e);
        repeat (3) step();
        chk({tag, " valid_early"}, 64'(sym_valid), 64'(1'b0));
        step();
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s scoreboard: got empty expected entry", tag);
            step();
        end else begin
            e = sb_q.pop_front();
            chk({tag, " mod_out"},    64'(mod_out),    64'(e.mod));
            chk({tag, " phase_inc"},  64'(phase_inc),  64'(e.inc));
            chk({tag, " sym_valid"},  64'(sym_valid),  64'(e.valid));
            chk({tag, " lfsr_stuck"}, 64'(lfsr_stuck), 64'(e.stuck));
            step();
            chk({tag, " valid_pulse_end"}, 64'(sym_valid), 64'(1'b0));
            chk({tag, " mod_hold"},        64'(mod_out),   64'(e.mod));
        end
        clk_1hz = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        logic seen_bad;

        reset_n = 1'b0;
        clk_1hz = 1'b1;
        lfsr    = 5'd0;
        mod_sel = M_ASK;
        sin_in  = DATA_W'(0);
        cos_in  = DATA_W'(0);
        repeat (3) step();

        chk("reset mod_out",    64'(mod_out),    64'(0));
        chk("reset phase_inc",  64'(phase_inc),  64'(INC0));
        chk("reset sym_valid",  64'(sym_valid),  64'(1'b0));
        chk("reset lfsr_stuck", 64'(lfsr_stuck), 64'(1'b0));

        // clk_1hz already high at release must not tick.
        sin_in  = DATA_W'(321);
        reset_n = 1'b1;
        seen_bad = 1'b0;
        repeat (12) begin
            step();
            if (sym_valid !== 1'b0 || mod_out !== DATA_W'(0)) seen_bad = 1'b1;
        end
        chk("high_at_release quiet", 64'(seen_bad), 64'(1'b0));
        clk_1hz = 1'b0;
        repeat (3) step();

        vecs.push_back(mk(5'b00000, M_BPSK, -2048,     0,  2047, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b00001, M_BPSK, -2048,     0, -2048, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b00001, M_FSK,    500,     0,   500, INC1, 1'b1, 1'b0));
        vecs.push_back(mk(5'b00010, M_FSK,    500,     0,   500, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b00101, M_FSK,   -300,     0,  -300, INC1, 1'b1, 1'b0));
        vecs.push_back(mk(5'b00100, M_ASK,    700,     0,     0, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b01001, M_ASK,    700,     0,   700, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b00010, M_QPSK,   600,  1000,   200, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b00011, M_QPSK,   600,  1000,   800, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b10000, M_QPSK,   600,  1000,  -800, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b00001, M_QPSK,   600,  1000,  -200, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b11111, M_QPSK, -2048, -2048, -2048, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b01100, M_QPSK, -2048, -2048,  2047, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b00010, M_QPSK,     0,  1001,   500, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b00001, M_QPSK,     0,     3,    -2, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b00100, M_BPSK,  2047,     0, -2047, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b00000, M_FSK,    500,     0,   500, INC0, 1'b1, 1'b0));
        vecs.push_back(mk(5'b00000, M_FSK,    500,     0,     0, INC0, 1'b0, 1'b1));
        vecs.push_back(mk(5'b00000, M_BPSK,   500,     0,     0, INC0, 1'b0, 1'b1));
        vecs.push_back(mk(5'b00001, M_FSK,    500,     0,   500, INC1, 1'b1, 1'b0));
        vecs.push_back(mk(5'b00100, M_BPSK,  2047,     0, -2047, INC0, 1'b1, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_symbol($sformatf("row%0d", i), vecs[i]);
        end

        // One-cycle latency from sin_in while holding BPSK bit 0.
        sin_in = DATA_W'(100);
        step();
        chk("latency neg", 64'(mod_out), 64'(-100));
        sin_in = DATA_W'(-2048);
        step();
        chk("latency sat", 64'(mod_out), 64'(2047));

        // Mode change mid-symbol stays on the latched ASK symbol.
        apply_symbol("ask_pre", mk(5'b00011, M_ASK, 700, 0, 700, INC0, 1'b1, 1'b0));
        mod_sel = M_QPSK;
        lfsr    = 5'b00010;
        cos_in  = DATA_W'(1000);
        sin_in  = DATA_W'(600);
        repeat (3) step();
        chk("midsym mod_out",   64'(mod_out),   64'(600));
        chk("midsym phase_inc", 64'(phase_inc), 64'(INC0));
        apply_symbol("qpsk_post", mk(5'b00010, M_QPSK, 600, 1000, 200, INC0, 1'b1, 1'b0));

        // FSK increment only moves on a tick.
        apply_symbol("fsk_mark", mk(5'b00001, M_FSK, 500, 0, 500, INC1, 1'b1, 1'b0));
        lfsr = 5'b00000;
        repeat (3) step();
        chk("fsk hold", 64'(phase_inc), 64'(INC1));
        apply_symbol("fsk_space", mk(5'b00010, M_FSK, 500, 0, 500, INC0, 1'b1, 1'b0));

        // Reset with a tick in flight discards the symbol.
        lfsr    = 5'b00001;
        clk_1hz = 1'b1;
        repeat (3) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst mod_out",    64'(mod_out),    64'(0));
        chk("async_rst phase_inc",  64'(phase_inc),  64'(INC0));
        chk("async_rst sym_valid",  64'(sym_valid),  64'(1'b0));
        chk("async_rst lfsr_stuck", 64'(lfsr_stuck), 64'(1'b0));
        clk_1hz = 1'b0;
        repeat (2) step();
        reset_n  = 1'b1;
        seen_bad = 1'b0;
        repeat (8) begin
            step();
            if (sym_valid !== 1'b0 || mod_out !== DATA_W'(0)) seen_bad = 1'b1;
        end
        chk("post_rst quiet", 64'(seen_bad), 64'(1'b0));
        apply_symbol("post_rst", mk(5'b00001, M_BPSK, 300, 0, 300, INC0, 1'b1, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
